// File: rtl/motor_controller_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : motor_controller_pkg                                     |
// | Description : Shared constants, types and helpers for the motor        |
// |               controller core slave ports.                             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package motor_controller_pkg;

  // Default number of sensor bits on the input port
  localparam int DEFAULT_WIDTH = 10;

  // Slave register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Which transitions of the filtered input are latched as events
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Per-bit event vector for the selected edge type, given current and previous value
  function automatic logic [31:0] edge_detect(input edge_type_e et,
                                              input logic [31:0] cur,
                                              input logic [31:0] prv);
    logic [31:0] res;
    case (et)
      EDGE_RISE: res = cur & ~prv;
      EDGE_FALL: res = ~cur & prv;
      default:   res = cur ^ prv;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_sensor_debounce.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : motor_sensor_debounce                                    |
// | Description : Tick-sampled majority-free debounce filter. A bit of     |
// |               filt only follows din once three consecutive tick        |
// |               samples agree. Compiled only when                        |
// |               MOTOR_SENSOR_DEBOUNCE_EN is defined.                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`ifdef MOTOR_SENSOR_DEBOUNCE_EN
module motor_sensor_debounce
  import motor_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] filt,
  output logic             valid
);

  localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               tick;
  logic [WIDTH-1:0]   hist0_q, hist0_d;
  logic [WIDTH-1:0]   hist1_q, hist1_d;
  logic [WIDTH-1:0]   filt_q, filt_d;
  logic [WIDTH-1:0]   stable;
  logic [1:0]         nsamp_q, nsamp_d;
  logic               valid_q, valid_d;

  // Prescaler tick, history shift and filter decision on each tick
  always_comb begin
    tick     = (cnt_q == c_cnt_w'(DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    hist0_d  = hist0_q;
    hist1_d  = hist1_q;
    filt_d   = filt_q;
    nsamp_d  = nsamp_q;
    valid_d  = valid_q;
    stable   = ~(din ^ hist0_q) & ~(din ^ hist1_q);
    if (tick) begin
      hist0_d = din;
      hist1_d = hist0_q;
      // Decisions only start once two history samples exist
      if (nsamp_q == 2'd2) begin
        filt_d  = (filt_q & ~stable) | (din & stable);
        valid_d = 1'b1;
      end else begin
        nsamp_d = nsamp_q + 1'b1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      hist0_q <= '0;
      hist1_q <= '0;
      filt_q  <= '0;
      nsamp_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
      filt_q  <= filt_d;
      nsamp_q <= nsamp_d;
      valid_q <= valid_d;
    end
  end

  assign filt  = filt_q;
  assign valid = valid_q;

endmodule
`endif
`default_nettype wire

// File: rtl/motor_controller_core_sensor_in.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : motor_controller_core_sensor_in                          |
// | Description : Avalon-MM sensor input port. Synchronises the sensor     |
// |               bus, optionally debounces it (MOTOR_SENSOR_DEBOUNCE_EN), |
// |               latches per-bit edge events and raises a maskable irq.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module motor_controller_core_sensor_in
  import motor_controller_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int EDGE_TYPE    = 0,
  parameter int DEBOUNCE_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_type_e c_edge_type = edge_type_e'(EDGE_TYPE[1:0]);

  if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE < 0 || EDGE_TYPE > 2 || DEBOUNCE_DIV < 2) begin : g_param_check
    $error("motor_controller_core_sensor_in: parameter out of range");
  end

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clr_vec;
  logic             filt_valid;
  logic             armed_q, armed_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en, rd_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

`ifdef MOTOR_SENSOR_DEBOUNCE_EN
  motor_sensor_debounce #(
    .WIDTH (WIDTH),
    .DIV   (DEBOUNCE_DIV)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (sync2_q),
    .filt  (filt),
    .valid (filt_valid)
  );
`else
  // filt is sync2 directly; it holds a real sample from the second edge after reset
  logic [1:0] vld_q, vld_d;

  // Shift in ones so vld_q[1] marks the first cycle sync2 holds a sampled value
  always_comb vld_d = {vld_q[0], 1'b1};

  // Startup validity shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  assign filt       = sync2_q;
  assign filt_valid = vld_q[1];
`endif

  // Input path: synchroniser, previous-value tracker and arming
  always_comb begin
    sync1_d  = in_port;
    sync2_d  = sync1_q;
    prev_d   = filt;
    armed_d  = armed_q | filt_valid;
    // prev only holds a genuine sample once armed, so edges before that are spurious
    edge_vec = armed_q ? WIDTH'(edge_detect(c_edge_type, 32'(filt), 32'(prev_q))) : '0;
  end

  // Register file updates and registered read mux
  always_comb begin
    wr_en      = chipselect & ~write_n;
    rd_en      = chipselect & ~read_n;
    mask_d     = mask_q;
    clr_vec    = '0;
    readdata_d = readdata_q;
    if (wr_en && address == ADDR_MASK) mask_d  = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE) clr_vec = writedata[WIDTH-1:0];
    // A new event in the clearing cycle wins over the clear
    cap_d = (cap_q & ~clr_vec) | edge_vec;
    irq_d = |(cap_d & mask_d);
    if (rd_en) begin
      case (address)
        ADDR_DATA: readdata_d = 32'(filt);
        ADDR_MASK: readdata_d = 32'(mask_q);
        ADDR_EDGE: readdata_d = 32'(cap_q);
        default:   readdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      armed_q    <= 1'b0;
      mask_q     <= '0;
      cap_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_controller_core_sensor_in.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_motor_controller_core_sensor_in                       |
// | Description : Scoreboard bench for the sensor input port. Three DUTs   |
// |               (rising, falling, any edge) share one stimulus stream.   |
// |               With MOTOR_SENSOR_DEBOUNCE_EN defined, directed debounce |
// |               checks run instead of the cycle-exact model.             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_motor_controller_core_sensor_in;

  localparam int DIV = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             read_n;
  logic             write_n;
  logic [31:0]      writedata;
  logic [9:0]       in_port;
  logic [2:0][31:0] rd_w;
  logic [2:0]       irq_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    motor_controller_core_sensor_in #(
      .WIDTH        (10),
      .EDGE_TYPE    (g),
      .DEBOUNCE_DIV (DIV)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (rd_w[g]),
      .irq        (irq_w[g])
    );
  end

  int cmp_count  = 0;
  int fail_count = 0;

  // Reference model state
  logic [2:0][31:0] exp_q[$];
  logic [2:0][31:0] dir_exp;
  logic [9:0]       samps[$];
  int               ncyc;
  logic [9:0]       m_mask;
  logic [2:0][9:0]  m_cap;
  logic [2:0]       m_irq;

  task automatic check(input string nm, input int t, input logic [31:0] act, input logic [31:0] req);
    cmp_count++;
    if (act !== req) begin
      fail_count++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, t, act, req, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    samps.delete();
    ncyc   = 0;
    m_mask = '0;
    m_cap  = '0;
    m_irq  = '0;
  endtask

  // Behavioural model: each posedge, samp[m] = in_port. DATA seen before edge m is
  // samp[m-2]; edge m latches the transition samp[m-3] -> samp[m-2] once m >= 4.
  initial begin
    logic             rd, wr;
    logic [9:0]       data_now, cur, old, clr;
    logic [2:0][9:0]  ev;
    logic [2:0][31:0] e;
    model_clear();
    forever begin
      @(posedge clk);
      if (reset) begin
        model_clear();
      end else begin
        rd = chipselect & ~read_n;
        wr = chipselect & ~write_n;
`ifdef MOTOR_SENSOR_DEBOUNCE_EN
        if (rd) exp_q.push_back(dir_exp);
`else
        data_now = (ncyc >= 2) ? samps[samps.size()-2] : 10'h0;
        if (rd) begin
          for (int t = 0; t < 3; t++) begin
            case (address)
              2'd0:    e[t] = {22'h0, data_now};
              2'd2:    e[t] = {22'h0, m_mask};
              2'd3:    e[t] = {22'h0, m_cap[t]};
              default: e[t] = 32'h0;
            endcase
          end
          exp_q.push_back(e);
        end
        ev = '0;
        if (ncyc >= 3) begin
          cur   = samps[samps.size()-2];
          old   = samps[samps.size()-3];
          ev[0] = cur & ~old;
          ev[1] = ~cur & old;
          ev[2] = cur ^ old;
        end
        clr = (wr && address == 2'd3) ? writedata[9:0] : 10'h0;
        if (wr && address == 2'd2) m_mask = writedata[9:0];
        for (int t = 0; t < 3; t++) begin
          m_cap[t] = (m_cap[t] & ~clr) | ev[t];
          m_irq[t] = |(m_cap[t] & m_mask);
        end
        samps.push_back(in_port);
        if (samps.size() > 3) void'(samps.pop_front());
        ncyc++;
`endif
      end
    end
  end

  // Monitor: compares readdata (held between reads) and irq on every falling edge
  initial begin
    logic [2:0][31:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last = '0;
      end else begin
        if (exp_q.size() > 0) last = exp_q.pop_front();
        for (int t = 0; t < 3; t++) begin
          check("readdata", t, rd_w[t], last[t]);
          check("irq", t, {31'h0, irq_w[t]}, {31'h0, m_irq[t]});
        end
      end
    end
  end

  // op: 0 idle, 1 read, 2 write, 3 strobes without chipselect
  task automatic cyc(input int op, input logic [1:0] a, input logic [31:0] wd, input logic [9:0] inv);
    @(negedge clk);
    in_port    = inv;
    address    = a;
    writedata  = wd;
    chipselect = (op == 1 || op == 2);
    read_n     = !(op == 1 || op == 3);
    write_n    = !(op == 2 || op == 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'd0, 32'h0, in_port);
  endtask

  task automatic rdx(input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    dir_exp = {e2, e1, e0};
    cyc(1, a, 32'h0, in_port);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 10'h3FF;
    dir_exp    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
`ifdef MOTOR_SENSOR_DEBOUNCE_EN
    in_port = 10'h000;
    idle(40);
    rdx(2'd0, 32'h0, 32'h0, 32'h0);
    // 5-cycle glitch on bit 2 must be rejected
    cyc(0, 2'd0, 32'h0, 10'h004);
    idle(4);
    cyc(0, 2'd0, 32'h0, 10'h000);
    idle(30);
    rdx(2'd0, 32'h0, 32'h0, 32'h0);
    rdx(2'd3, 32'h0, 32'h0, 32'h0);
    // Held level is accepted within three ticks
    cyc(0, 2'd0, 32'h0, 10'h004);
    idle(17);
    rdx(2'd0, 32'h4, 32'h4, 32'h4);
    rdx(2'd3, 32'h4, 32'h0, 32'h4);
    idle(3);
`else
    // Reset release with all inputs high: no spurious events
    idle(4);
    cyc(1, 2'd0, 32'h0, in_port);
    cyc(1, 2'd3, 32'h0, in_port);
    cyc(1, 2'd1, 32'h0, in_port);
    cyc(2, 2'd0, 32'hFFFF_FFFF, in_port);
    cyc(1, 2'd0, 32'h0, in_port);
    // Rising edge on bit 0 with mask bit 0
    cyc(2, 2'd2, 32'h1, in_port);
    cyc(0, 2'd0, 32'h0, 10'h000);
    idle(4);
    cyc(2, 2'd3, 32'hFFFF_FFFF, in_port);
    idle(2);
    cyc(0, 2'd0, 32'h0, 10'h001);
    idle(3);
    cyc(1, 2'd3, 32'h0, in_port);
    cyc(2, 2'd3, 32'h1, in_port);
    cyc(1, 2'd3, 32'h0, in_port);
    cyc(1, 2'd2, 32'h0, in_port);
    // W1C of bit 3 in the same cycle a new bit-3 edge is detected
    cyc(0, 2'd0, 32'h0, 10'h008);
    idle(3);
    cyc(0, 2'd0, 32'h0, 10'h000);
    idle(3);
    cyc(0, 2'd0, 32'h0, 10'h008);
    cyc(0, 2'd0, 32'h0, 10'h008);
    cyc(2, 2'd3, 32'h8, 10'h008);
    cyc(1, 2'd3, 32'h0, in_port);
    // Masking: events on bits 0 and 9, only bit 9 enabled
    cyc(2, 2'd3, 32'h3FF, 10'h000);
    idle(3);
    cyc(2, 2'd3, 32'h3FF, in_port);
    cyc(2, 2'd2, 32'h200, 10'h201);
    idle(3);
    cyc(1, 2'd3, 32'h0, in_port);
    cyc(2, 2'd2, 32'h0, in_port);
    cyc(1, 2'd3, 32'h0, in_port);
    idle(2);
    // Reset with irq high and a read in flight
    cyc(2, 2'd2, 32'h3FF, 10'h000);
    cyc(0, 2'd0, 32'h0, 10'h3FF);
    idle(3);
    cyc(1, 2'd3, 32'h0, in_port);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    #1;
    for (int t = 0; t < 3; t++) begin
      check("reset_irq", t, {31'h0, irq_w[t]}, 32'h0);
      check("reset_readdata", t, rd_w[t], 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int t = 0; t < 3; t++) check("irq_in_reset", t, {31'h0, irq_w[t]}, 32'h0);
    end
    reset = 1'b0;
    idle(6);
    cyc(1, 2'd3, 32'h0, in_port);
    cyc(1, 2'd2, 32'h0, in_port);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [9:0]  nin;
      logic [31:0] wd;
      r   = int'($urandom_range(0, 99));
      nin = in_port;
      if ($urandom_range(0, 3) == 0) nin = nin ^ (10'h1 << $urandom_range(0, 9));
      wd  = $urandom;
      if (r < 30)      cyc(1, 2'($urandom_range(0, 3)), 32'h0, nin);
      else if (r < 40) cyc(2, 2'd2, wd, nin);
      else if (r < 50) cyc(2, 2'd3, wd, nin);
      else if (r < 54) cyc(2, 2'($urandom_range(0, 1)), wd, nin);
      else if (r < 58) cyc(3, 2'($urandom_range(0, 3)), wd, nin);
      else             cyc(0, 2'd0, 32'h0, nin);
    end
    idle(4);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
`default_nettype wire
